// File: rtl/pipe_stage_pkg.sv
// Shared pipeline constants: stall encodings, bus widths and the EX/MEM payload layout.
// Each stage boundary keeps its NOP payload next to its struct so they stay in step.
package pipe_stage_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_BUS_W = 6;
  localparam int WORD_W      = 32;
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  localparam logic [7:0] ALUOP_NOP      = 8'h00;
  localparam logic [2:0] TLB_FROM_INDEX = 3'd1;

  typedef struct packed {
    logic [WORD_W-1:0]   pc;
    logic [7:0]          aluop;
    logic [4:0]          wd;
    logic                wreg;
    logic [WORD_W-1:0]   wdata;
    logic [2*WORD_W-1:0] hilo;
    logic [2:0]          tlb_sel;
    logic [110:0]        rsvd;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

  // NOP bubble: no register write, NOP aluop, TLB select parked on FromIndex.
  localparam ex_mem_t EX_MEM_NOP = {ZERO_WORD, ALUOP_NOP, 5'd0, 1'b0, ZERO_WORD,
                                    {2{ZERO_WORD}}, TLB_FROM_INDEX, 111'd0};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + carry side-channel with stall, flush,
// bubble insertion and saturating stall/bubble performance counters.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int              DATA_W      = 256,
  parameter int              CARRY_W     = 66,
  parameter int              STALL_W     = STALL_BUS_W,
  parameter int              STAGE_IDX   = 3,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit              BUBBLE_MODE = 1'b0,
  parameter int              CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] i_stall,
  input  logic               i_flush,
  input  logic [DATA_W-1:0]  i_in_data,
  input  logic               i_in_valid,
  input  logic [CARRY_W-1:0] i_carry,
  input  logic               i_clr_cnt,
  output logic [DATA_W-1:0]  o_out_data,
  output logic               o_out_valid,
  output logic [CARRY_W-1:0] o_carry,
  output logic [CNT_W-1:0]   o_stall_cycles,
  output logic [CNT_W-1:0]   o_bubble_cycles
);

  logic               w_up;
  logic               w_dn;
  logic               w_bubble;
  logic               w_hold;
  logic               w_unused_stall;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic [CARRY_W-1:0] r_carry;

  assign w_up           = (i_stall[STAGE_IDX] == STOP);
  assign w_dn           = (i_stall[STAGE_IDX+1] == STOP);
  assign w_bubble       = !i_flush && w_up && !w_dn;
  assign w_hold         = !i_flush && w_up && w_dn;
  assign w_unused_stall = ^i_stall;

  // up=0 with dn=1 is not a legal stall vector; it falls into the advance branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= NOP_VALUE;
      r_valid <= 1'b0;
      r_carry <= '0;
    end else if (i_flush) begin
      r_data  <= NOP_VALUE;
      r_valid <= 1'b0;
      r_carry <= '0;
    end else if (w_bubble) begin
      if (!BUBBLE_MODE) r_data <= NOP_VALUE;
      r_valid <= 1'b0;
      r_carry <= i_carry;
    end else if (!w_up) begin
      r_data  <= i_in_data;
      r_valid <= i_in_valid;
      r_carry <= '0;
    end else begin
      r_carry <= i_carry;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_hold),
    .i_clr (i_clr_cnt),
    .o_cnt (o_stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_bubble),
    .i_clr (i_clr_cnt),
    .o_cnt (o_bubble_cycles)
  );

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_carry     = r_carry;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (w_up || !w_dn) else $error("pipe_stage_reg: downstream stalled while upstream runs");
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a NOP-bubble instance (4-bit counters) and a hold-bubble
// instance share stimulus; table vectors, hand sequences, then randomized model checks.
module tb_pipe_stage_reg;
  import pipe_stage_pkg::*;

  localparam logic [255:0] D1 = {8{32'hD1D1_0001}};
  localparam logic [255:0] D2 = {8{32'hD2D2_0002}};
  localparam logic [255:0] D3 = {8{32'hD3D3_0003}};
  localparam logic [255:0] DA = {32{8'hA5}};
  localparam logic [65:0]  CA = 66'h3_DEAD_BEEF_0000_0001;
  localparam logic [65:0]  C0 = 66'h1_0000_0000_1234_5678;
  localparam logic [65:0]  C1 = 66'h2_FFFF_0000_8765_4321;
  localparam logic [255:0] NOP0 = EX_MEM_NOP;
  localparam logic [255:0] NOP1 = '0;

  logic         clk, rst, flush, in_valid, clr;
  logic [5:0]   stall;
  logic [255:0] in_data;
  logic [65:0]  carry;
  logic [255:0] d0, d1;
  logic         v0, v1;
  logic [65:0]  c0, c1;
  logic [3:0]   sc0, bc0;
  logic [15:0]  sc1, bc1;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(.NOP_VALUE(NOP0), .BUBBLE_MODE(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_in_data(in_data),
    .i_in_valid(in_valid), .i_carry(carry), .i_clr_cnt(clr), .o_out_data(d0),
    .o_out_valid(v0), .o_carry(c0), .o_stall_cycles(sc0), .o_bubble_cycles(bc0));

  pipe_stage_reg #(.NOP_VALUE(NOP1), .BUBBLE_MODE(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_in_data(in_data),
    .i_in_valid(in_valid), .i_carry(carry), .i_clr_cnt(clr), .o_out_data(d1),
    .o_out_valid(v1), .o_carry(c1), .o_stall_cycles(sc1), .o_bubble_cycles(bc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   stall;
    logic         flush;
    logic [255:0] data;
    logic         valid;
    logic [65:0]  carry;
    logic         clr;
    logic [255:0] exp_d0;
    logic [255:0] exp_d1;
    logic         exp_v;
    logic [65:0]  exp_c;
    int           exp_sc;
    int           exp_bc;
  } vec_t;

  vec_t tbl[9];

  // Reference model state, index 0 = dut0, 1 = dut1.
  logic [255:0] m_data[2];
  logic         m_valid[2];
  logic [65:0]  m_carry[2];
  int           m_stl[2];
  int           m_bub[2];
  int           m_max[2] = '{15, 65535};
  bit           m_hold_on_bubble[2] = '{1'b0, 1'b1};
  logic [255:0] m_nop[2];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic [255:0] d,
                       input logic v, input logic [65:0] c, input logic cl);
    stall = s; flush = f; in_data = d; in_valid = v; carry = c; clr = cl;
  endtask

  task automatic check_both(input string tag, input logic [255:0] e0, input logic [255:0] e1,
                            input logic ev, input logic [65:0] ec, input int esc0, input int esc1,
                            input int ebc);
    chk({tag, " d0"}, d0, e0);
    chk({tag, " d1"}, d1, e1);
    chk({tag, " v0"}, 256'(v0), 256'(ev));
    chk({tag, " v1"}, 256'(v1), 256'(ev));
    chk({tag, " c0"}, 256'(c0), 256'(ec));
    chk({tag, " c1"}, 256'(c1), 256'(ec));
    chk({tag, " sc0"}, 256'(sc0), 256'(esc0));
    chk({tag, " sc1"}, 256'(sc1), 256'(esc1));
    chk({tag, " bc0"}, 256'(bc0), 256'(ebc));
    chk({tag, " bc1"}, 256'(bc1), 256'(ebc));
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = m_nop[k]; m_valid[k] = 1'b0; m_carry[k] = '0;
      m_stl[k] = 0; m_bub[k] = 0;
    end
  endtask

  // One clock of the stage as described in words: flush, bubble, advance, hold.
  task automatic model_step();
    bit up, dn;
    up = stall[3];
    dn = stall[4];
    for (int k = 0; k < 2; k++) begin
      bit is_bubble, is_hold;
      is_bubble = !flush && up && !dn;
      is_hold   = !flush && up && dn;
      if (flush) begin
        m_data[k] = m_nop[k]; m_valid[k] = 1'b0; m_carry[k] = '0;
      end else if (is_bubble) begin
        if (!m_hold_on_bubble[k]) m_data[k] = m_nop[k];
        m_valid[k] = 1'b0; m_carry[k] = carry;
      end else if (!up) begin
        m_data[k] = in_data; m_valid[k] = in_valid; m_carry[k] = '0;
      end else begin
        m_carry[k] = carry;
      end
      if (clr) begin
        m_stl[k] = 0; m_bub[k] = 0;
      end else begin
        if (is_hold)   m_stl[k] = sat_inc(m_stl[k], m_max[k]);
        if (is_bubble) m_bub[k] = sat_inc(m_bub[k], m_max[k]);
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " d0"}, d0, m_data[0]);
    chk({tag, " d1"}, d1, m_data[1]);
    chk({tag, " v0"}, 256'(v0), 256'(m_valid[0]));
    chk({tag, " v1"}, 256'(v1), 256'(m_valid[1]));
    chk({tag, " c0"}, 256'(c0), 256'(m_carry[0]));
    chk({tag, " c1"}, 256'(c1), 256'(m_carry[1]));
    chk({tag, " sc0"}, 256'(sc0), 256'(m_stl[0]));
    chk({tag, " sc1"}, 256'(sc1), 256'(m_stl[1]));
    chk({tag, " bc0"}, 256'(bc0), 256'(m_bub[0]));
    chk({tag, " bc1"}, 256'(bc1), 256'(m_bub[1]));
  endtask

  initial begin
    m_nop[0] = NOP0;
    m_nop[1] = NOP1;

    //            stall      fl  data  v  carry clr  exp_d0 exp_d1 v  exp_c sc bc
    tbl[0] = '{6'b000000, 0, D1, 1, CA, 0, D1,   D1,   1, '0, 0, 0};
    tbl[1] = '{6'b001111, 0, D2, 1, C0, 0, NOP0, D1,   0, C0, 0, 1};
    tbl[2] = '{6'b001111, 0, D2, 1, C1, 0, NOP0, D1,   0, C1, 0, 2};
    tbl[3] = '{6'b000000, 0, D2, 1, C1, 0, D2,   D2,   1, '0, 0, 2};
    tbl[4] = '{6'b011111, 0, D3, 1, C0, 0, D2,   D2,   1, C0, 1, 2};
    tbl[5] = '{6'b011111, 0, D3, 1, C1, 0, D2,   D2,   1, C1, 2, 2};
    tbl[6] = '{6'b011111, 0, D3, 1, C0, 0, D2,   D2,   1, C0, 3, 2};
    tbl[7] = '{6'b011111, 1, D3, 1, C1, 0, NOP0, NOP1, 0, '0, 3, 2};
    tbl[8] = '{6'b000000, 0, D1, 0, C1, 1, D1,   D1,   0, '0, 0, 0};

    rst = 1'b1;
    drive(6'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    #2;
    check_both("reset", NOP0, NOP1, 1'b0, '0, 0, 0, 0);
    #10 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].data, tbl[i].valid, tbl[i].carry, tbl[i].clr);
      step();
      check_both($sformatf("vec%0d", i), tbl[i].exp_d0, tbl[i].exp_d1, tbl[i].exp_v,
                 tbl[i].exp_c, tbl[i].exp_sc, tbl[i].exp_sc, tbl[i].exp_bc);
    end

    // Long hold: the 4-bit counter pins at 15, then clear wins over a concurrent hold.
    for (int i = 0; i < 20; i++) begin
      drive(6'b011111, 1'b0, D3, 1'b1, C0, 1'b0);
      step();
    end
    check_both("sat", D1, D1, 1'b0, C0, 15, 20, 0);
    drive(6'b011111, 1'b0, D3, 1'b1, C1, 1'b1);
    step();
    check_both("clr", D1, D1, 1'b0, C1, 0, 0, 0);

    // Asynchronous reset landing between edges.
    drive(6'b000000, 1'b0, DA, 1'b1, CA, 1'b0);
    step();
    drive(6'b001111, 1'b0, DA, 1'b1, C0, 1'b0);
    step();
    drive(6'b000000, 1'b0, DA, 1'b1, CA, 1'b0);
    step();
    drive(6'b011111, 1'b0, D2, 1'b1, C1, 1'b0);
    step();
    check_both("pre_rst", DA, DA, 1'b1, C1, 1, 1, 1);
    #2 rst = 1'b1;
    #1;
    check_both("async_rst", NOP0, NOP1, 1'b0, '0, 0, 0, 0);

    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int sel;
      logic [5:0] s;
      logic [255:0] d;
      sel = int'($urandom_range(2));
      s = 6'($urandom);
      s[3] = (sel != 0);
      s[4] = (sel == 2);
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      drive(s, ($urandom_range(7) == 0), d, 1'($urandom), {2'($urandom_range(3)), $urandom, $urandom},
            ($urandom_range(63) == 0));
      step();
      model_step();
      model_check($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
